// File: rtl/area_pkg.sv
// area_pkg: shared geometry constants, pixel types and the fixed 16-colour palette.
// Rev 1.0
`default_nettype none

package area_pkg;

  localparam int AREA_W  = 891;
  localparam int AREA_H  = 240;
  localparam int VIEW_W  = 320;
  localparam int CAM_MAX = AREA_W - VIEW_W;
  localparam int ADDR_W  = 18;

  typedef logic [23:0] rgb_t;
  typedef logic [3:0]  pal_idx_t;

  // Index 0 doubles as the transparent key colour.
  localparam rgb_t PALETTE [0:15] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
    24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
    24'h000080, 24'h808000, 24'h008080, 24'h800080
  };

endpackage

`default_nettype wire

// File: rtl/area_palette_lut.sv
// area_palette_lut: registered palette index to RGB lookup with valid/transparent flags.
// Rev 1.0
`default_nettype none

module area_palette_lut
  import area_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     valid_in,
  input  pal_idx_t idx_in,
  output rgb_t     rgb_out,
  output logic     rgb_valid,
  output logic     transparent
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_out     <= '0;
      rgb_valid   <= 1'b0;
      transparent <= 1'b0;
    end else begin
      rgb_out     <= valid_in ? PALETTE[idx_in] : '0;
      rgb_valid   <= valid_in;
      transparent <= valid_in && (idx_in == 4'h0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/area_pixel_fetch.sv
// area_pixel_fetch: VGA scan position plus camera offset -> area RAM address -> RGB pixel.
// Rev 1.0
`default_nettype none

module area_pixel_fetch
  import area_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        camera_x_req,
  input  logic [3:0]        ram_data,
  output logic [ADDR_W-1:0] read_address,
  output logic [23:0]       rgb_out,
  output logic              rgb_valid,
  output logic              transparent
);

  logic [9:0]        cam_x;
  logic [9:0]        lx1;
  logic [8:0]        ly1;
  logic [ADDR_W-1:0] row_base;
  logic              v1, v2, v3;
  pal_idx_t          idx3;
  logic [8:0]        draw_row;
  logic [8:0]        draw_col;
  logic              unused_lsbs;

  // Display is 2x scaled, so the screen LSBs never reach the logical grid.
  assign draw_row    = DrawY[9:1];
  assign draw_col    = DrawX[9:1];
  assign unused_lsbs = ^{DrawX[0], DrawY[0]};

  // Camera is sampled once per frame so the view never tears mid-scan.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cam_x <= '0;
    end else if (frame_start) begin
      cam_x <= (camera_x_req > 10'(CAM_MAX)) ? 10'(CAM_MAX) : camera_x_req;
    end
  end

  // Row base is accumulated rather than multiplied: rows only hold, step by one or restart.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lx1      <= '0;
      ly1      <= '0;
      v1       <= 1'b0;
      row_base <= '0;
    end else begin
      lx1 <= {1'b0, draw_col} + cam_x;
      ly1 <= draw_row;
      v1  <= pix_valid && (draw_row < 9'(AREA_H));
      if (draw_row == 9'd0) begin
        row_base <= '0;
      end else if (draw_row != ly1) begin
        row_base <= row_base + ADDR_W'(AREA_W);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      v2           <= 1'b0;
      idx3         <= '0;
      v3           <= 1'b0;
    end else begin
      read_address <= v1 ? (row_base + ADDR_W'(lx1)) : '0;
      v2           <= v1;
      idx3         <= ram_data;
      v3           <= v2;
    end
  end

  area_palette_lut u_palette (
    .clk         (Clk),
    .rst         (Reset),
    .valid_in    (v3),
    .idx_in      (idx3),
    .rgb_out     (rgb_out),
    .rgb_valid   (rgb_valid),
    .transparent (transparent)
  );

endmodule

`default_nettype wire

// File: tb/tb_area_pixel_fetch.sv
// tb_area_pixel_fetch: table vectors and raster sequences checked through a latency scoreboard.
// Rev 1.0
`default_nettype none

module tb_area_pixel_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  camera_x_req;
  logic [3:0]  ram_data;
  logic [17:0] read_address;
  logic [23:0] rgb_out;
  logic        rgb_valid;
  logic        transparent;

  int n_cmp = 0;
  int n_bad = 0;
  int max_addr = 0;

  localparam logic [23:0] PAL [0:15] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
    24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
    24'h000080, 24'h808000, 24'h008080, 24'h800080
  };

  typedef struct {
    int addr;
    bit v;
  } exp_t;

  typedef struct {
    bit fs;
    bit pv;
    int x;
    int y;
    int cam;
    int addr;
    bit v;
  } vec_t;

  exp_t addr_q[$];
  exp_t rgb_q[$];
  vec_t tbl[15];

  area_pixel_fetch dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .camera_x_req (camera_x_req),
    .ram_data     (ram_data),
    .read_address (read_address),
    .rgb_out      (rgb_out),
    .rgb_valid    (rgb_valid),
    .transparent  (transparent)
  );

  always #5 Clk = ~Clk;

  // RAM model: content derived from the address, so address 0 holds 3 and address 3 holds 0.
  assign ram_data = read_address[3:0] ^ 4'h3;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_i, input bit fs, input bit pv, input int x, input int y,
                      input int cam, input int exp_addr, input bit exp_v);
    exp_t e;
    logic [17:0] a;
    logic [3:0]  idx;
    Reset        = rst_i;
    frame_start  = fs;
    pix_valid    = pv;
    DrawX        = 10'(x);
    DrawY        = 10'(y);
    camera_x_req = 10'(cam);
    e.v    = exp_v && !rst_i;
    e.addr = e.v ? exp_addr : 0;
    addr_q.push_back(e);
    rgb_q.push_back(e);
    if (rst_i) begin
      for (int i = 0; i < addr_q.size(); i++) begin addr_q[i].v = 0; addr_q[i].addr = 0; end
      for (int i = 0; i < rgb_q.size(); i++)  begin rgb_q[i].v = 0;  rgb_q[i].addr = 0;  end
    end
    @(posedge Clk);
    #1;
    if (int'(read_address) > max_addr) max_addr = int'(read_address);
    if (rst_i) begin
      chk("reset_state", {5'd0, read_address, rgb_valid, transparent, 7'd0},
          32'd0);
      chk("reset_rgb", {8'd0, rgb_out}, 32'd0);
    end
    if (addr_q.size() == 2) begin
      e = addr_q.pop_front();
      chk("read_address", {14'd0, read_address}, 32'(e.addr));
    end
    if (rgb_q.size() == 4) begin
      e = rgb_q.pop_front();
      a = 18'(e.addr);
      idx = a[3:0] ^ 4'h3;
      chk("rgb_out", {8'd0, rgb_out}, e.v ? {8'd0, PAL[idx]} : 32'd0);
      chk("rgb_valid", {31'd0, rgb_valid}, {31'd0, e.v});
      chk("transparent", {31'd0, transparent}, {31'd0, e.v && (idx == 4'h0)});
    end
  endtask

  initial begin
    //          fs  pv   x    y   cam  addr  v
    tbl[0]  = '{1, 0,   0,   0,   0,    0, 0};
    tbl[1]  = '{0, 1,   0,   0,   0,    0, 1};
    tbl[2]  = '{0, 1,   6,   0,   0,    3, 1};
    tbl[3]  = '{0, 1,  10,   0,   0,    5, 1};
    tbl[4]  = '{0, 1,  10,   1,   0,    5, 1};
    tbl[5]  = '{0, 1,  10,   2,   0,  896, 1};
    tbl[6]  = '{0, 1,  10,   3,   0,  896, 1};
    tbl[7]  = '{0, 0, 700,   3,   0,    0, 0};
    tbl[8]  = '{0, 1,  10,   4, 100, 1787, 1};
    tbl[9]  = '{1, 1,  10,   4, 100, 1787, 1};
    tbl[10] = '{0, 1,  10,   4, 100, 1887, 1};
    tbl[11] = '{0, 1,   0,   0, 100,  100, 1};
    tbl[12] = '{1, 1,   0,   0, 900,  100, 1};
    tbl[13] = '{0, 1,   0,   0, 900,  571, 1};
    tbl[14] = '{0, 1, 639,   0, 900,  890, 1};

    // Reset held two cycles with pix_valid high, then idle.
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i])
      step(0, tbl[i].fs, tbl[i].pv, tbl[i].x, tbl[i].y, tbl[i].cam, tbl[i].addr, tbl[i].v);

    // Compressed raster at the clamped camera: first and last column of every row.
    max_addr = 0;
    for (int y = 0; y < 480; y++) begin
      step(0, 0, 1, 0,   y, 900, (y / 2) * 891 + 0   + 571, 1);
      step(0, 0, 1, 639, y, 900, (y / 2) * 891 + 319 + 571, 1);
    end
    step(0, 0, 1, 100, 480, 900, 0, 0);
    step(0, 0, 1, 100, 481, 900, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 900, 0, 0);
    chk("max_address", 32'(max_addr), 32'd213839);

    // Reset lands two cycles after a valid pixel: its address is out, its colour must never appear.
    step(0, 0, 1, 20, 0, 900, 581, 1);
    step(0, 0, 0, 0,  0, 900, 0, 0);
    step(1, 0, 0, 0,  0, 900, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    // Camera is back to 0 after reset.
    step(0, 0, 1, 6, 0, 0, 3, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
